// File: rtl/layer_sequencer_pkg.sv
// Shared encodings for the layer sequencer.
// The network top imports this package to decode state and error codes for debug.
package layer_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    OUTPUT = 3'd3,
    ERROR  = 3'd4
  } seq_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;

  // A single-layer network still needs a 1-bit layer_idx.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Sample-in, neuron-control and result-out signals of the layer sequencer.
// The master modport is the sequencer side.
interface layer_sequencer_if #(
  parameter int M     = 4,
  parameter int IDX_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic             ld_input;
  logic             neuron_start;
  logic [M-1:0]     neuron_ready;
  logic             ld_layer_out;
  logic [IDX_W-1:0] layer_idx;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             err;
  logic [1:0]       err_code;
  logic             clr_err;

  modport master (
    input  in_valid, neuron_ready, out_ready, clr_err,
    output in_ready, ld_input, neuron_start, ld_layer_out, layer_idx,
           out_valid, busy, err, err_code
  );

  modport slave (
    output in_valid, neuron_ready, out_ready, clr_err,
    input  in_ready, ld_input, neuron_start, ld_layer_out, layer_idx,
           out_valid, busy, err, err_code
  );
endinterface

// File: rtl/layer_sequencer_watchdog.sv
// Clearable up-counter for the neuron-ready wait; tc flags TIMEOUT-1.
// The parent stops incrementing once tc is seen, so the counter never wraps.
module layer_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/layer_sequencer.sv
// Sequences one inference through NUM_LAYERS layers of M neurons: start pulse,
// wait for all-ready, latch the layer, advance; watchdog and ready-consistency errors.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int M          = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic               clk,
  input  logic               rst,
  layer_sequencer_if.master  sif
);
  localparam int               IDX_W = idx_width(NUM_LAYERS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_LAYERS - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] layer_idx_q, layer_idx_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             all_rdy, any_rdy;
  logic             wd_clr, wd_inc, wd_tc;

  assign all_rdy = &sif.neuron_ready;
  assign any_rdy = |sif.neuron_ready;

  layer_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk (clk),
    .rst (rst),
    .clr (wd_clr),
    .inc (wd_inc),
    .tc  (wd_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      layer_idx_q <= '0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    err_code_d  = err_code_q;
    wd_clr      = 1'b0;
    wd_inc      = 1'b0;
    case (state_q)
      IDLE: if (sif.in_valid) begin
        layer_idx_d = '0;
        state_d     = START;
      end
      START: begin
        wd_clr  = 1'b1;
        state_d = WAIT;
      end
      // Full ready beats a partial one, which beats the watchdog.
      WAIT: begin
        if (all_rdy) begin
          wd_clr = 1'b1;
          if (layer_idx_q == LAST) state_d = OUTPUT;
          else begin
            layer_idx_d = layer_idx_q + 1'b1;
            state_d     = START;
          end
        end else if (any_rdy) begin
          state_d    = ERROR;
          err_code_d = ERR_MISMATCH;
        end else if (wd_tc) begin
          state_d    = ERROR;
          err_code_d = ERR_TIMEOUT;
        end else begin
          wd_inc = 1'b1;
        end
      end
      OUTPUT: if (sif.out_ready) state_d = IDLE;
      ERROR: if (sif.clr_err) begin
        err_code_d  = ERR_NONE;
        layer_idx_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sif.in_ready     = (state_q == IDLE);
    sif.ld_input     = (state_q == IDLE) && sif.in_valid;
    sif.neuron_start = (state_q == START);
    sif.ld_layer_out = (state_q == WAIT) && all_rdy;
    sif.out_valid    = (state_q == OUTPUT);
    sif.busy         = (state_q != IDLE);
    sif.err          = (state_q == ERROR);
    sif.err_code     = err_code_q;
    sif.layer_idx    = layer_idx_q;
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed scenarios with randomized neuron latency, backpressure and don't-care inputs;
// expected outputs come from cycle arithmetic on the layer period N+3.
module tb_layer_sequencer;
  localparam int NL = 3, M = 4, TO = 32, IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_sequencer_if #(.M(M), .IDX_W(IW)) ifc ();

  layer_sequencer #(.NUM_LAYERS(NL), .M(M), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .sif (ifc)
  );

  int vectors = 0, miscompares = 0;
  int cyc = -1, pend = -1, nrn_n = 10;
  bit nrn_en = 1'b1;
  logic drv_in_valid = 1'b0, drv_out_ready = 1'b0, drv_clr_err = 1'b0;
  logic [M-1:0] drv_ready = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit e_start, input bit e_ldl, input bit e_ldi,
                         input bit e_ov, input bit e_busy, input bit e_err,
                         input logic [1:0] e_code, input int e_idx);
    chk({tag, ".neuron_start"}, 32'(ifc.neuron_start), 32'(e_start));
    chk({tag, ".ld_layer_out"}, 32'(ifc.ld_layer_out), 32'(e_ldl));
    chk({tag, ".ld_input"},     32'(ifc.ld_input),     32'(e_ldi));
    chk({tag, ".out_valid"},    32'(ifc.out_valid),    32'(e_ov));
    chk({tag, ".busy"},         32'(ifc.busy),         32'(e_busy));
    chk({tag, ".in_ready"},     32'(ifc.in_ready),     32'(!e_busy));
    chk({tag, ".err"},          32'(ifc.err),          32'(e_err));
    chk({tag, ".err_code"},     32'(ifc.err_code),     32'(e_code));
    if (e_idx >= 0) chk({tag, ".layer_idx"}, 32'(ifc.layer_idx), 32'(e_idx));
  endtask

  // Behavioural neurons: all raise ready N+2 cycles after the start they saw.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    ifc.in_valid  = drv_in_valid;
    ifc.out_ready = drv_out_ready;
    ifc.clr_err   = drv_clr_err;
    if (nrn_en && pend >= 0 && cyc == pend + nrn_n + 2) begin
      ifc.neuron_ready = '1;
      pend = -1;
    end else begin
      ifc.neuron_ready = drv_ready;
    end
    @(negedge clk);
    if (ifc.neuron_start) pend = cyc;
  endtask

  task automatic idle_inputs();
    drv_in_valid = 1'b0; drv_out_ready = 1'b0; drv_clr_err = 1'b0; drv_ready = '0;
  endtask

  // One full inference accepted at cycle 0; bp = cycles of out_ready low in OUTPUT.
  task automatic run_nominal(input int n, input int bp, input bit spur);
    int p, ov0, ec, idx;
    bit bsy;
    p = n + 3; ov0 = 1 + NL * p; ec = ov0 + bp + 1;
    nrn_n = n; nrn_en = 1'b1; pend = -1; cyc = -1;
    for (int c = 0; c <= ec; c++) begin
      drv_in_valid  = (c == 0) ? 1'b1 : (c == ec) ? 1'b0 : 1'($urandom_range(0, 1));
      drv_out_ready = (c < ov0) ? 1'($urandom_range(0, 1)) : (c < ov0 + bp) ? 1'b0 : 1'b1;
      drv_clr_err   = 1'($urandom_range(0, 1));
      drv_ready     = (spur && c >= 1 && c < ov0 && (c - 1) % p == 0) ? '1 : '0;
      tick();
      bsy = (c >= 1 && c < ec);
      idx = (c == 0) ? -1 : (((c - 1) / p < NL) ? (c - 1) / p : NL - 1);
      chk_all(spur ? "spur" : "nom",
              (c >= 1 && c < ov0 && (c - 1) % p == 0),
              (c >= p && c < ov0 && c % p == 0),
              (c == 0), (c >= ov0 && c < ec), bsy, 1'b0, 2'b00, idx);
    end
    idle_inputs();
  endtask

  initial begin
    int n, p, mc;
    logic [M-1:0] pat;
    idle_inputs();
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0; ifc.clr_err = 1'b0; ifc.neuron_ready = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 2'b00, 0);
    rst = 1'b0;
    tick();
    chk_all("idle", 0, 0, 0, 0, 0, 0, 2'b00, 0);

    // Nominal timing with N=10, then backpressure, then random latencies
    run_nominal(10, 0, 1'b0);
    run_nominal(10, 5, 1'b0);
    for (int k = 0; k < 4; k++)
      run_nominal($urandom_range(1, 20), $urandom_range(0, 6), 1'($urandom_range(0, 1)));

    // Timeout: neurons silent; early clr_err in WAIT must be ignored
    nrn_en = 1'b0; pend = -1; cyc = -1;
    for (int c = 0; c <= 41; c++) begin
      drv_in_valid  = (c == 0);
      drv_clr_err   = (c == 10 || c == 40);
      drv_out_ready = 1'($urandom_range(0, 1));
      tick();
      chk_all("timeout", (c == 1), 1'b0, (c == 0), 1'b0, (c >= 1 && c <= 40),
              (c >= 34 && c <= 40), (c >= 34 && c <= 40) ? 2'b01 : 2'b00, (c == 0) ? -1 : 0);
    end
    idle_inputs();

    // Mismatch in WAIT of layer 1 with a random partial-ready pattern
    for (int k = 0; k < 2; k++) begin
      n = $urandom_range(1, 12); p = n + 3;
      mc = $urandom_range(p + 2, 2 * p - 1);
      pat = M'($urandom_range(1, 14));
      nrn_n = n; nrn_en = 1'b1; pend = -1; cyc = -1;
      for (int c = 0; c <= mc + 4; c++) begin
        drv_in_valid = (c == 0);
        drv_ready    = (c == mc) ? pat : '0;
        drv_clr_err  = (c == mc + 3);
        tick();
        chk_all("mismatch", (c == 1 || c == 1 + p), (c == p), (c == 0), 1'b0,
                (c >= 1 && c <= mc + 3), (c > mc && c <= mc + 3),
                (c > mc && c <= mc + 3) ? 2'b10 : 2'b00,
                (c == 0) ? -1 : (c <= p) ? 0 : (c <= mc + 3) ? 1 : 0);
      end
      idle_inputs();
    end

    // Reset during WAIT of layer 1, then a fresh inference with the same timing
    n = $urandom_range(2, 15); p = n + 3;
    nrn_n = n; nrn_en = 1'b1; pend = -1; cyc = -1;
    for (int c = 0; c <= p + 3; c++) begin
      drv_in_valid = (c == 0);
      tick();
    end
    chk("midrst.pre_idx", 32'(ifc.layer_idx), 32'd1);
    rst = 1'b1;
    #1;
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 2'b00, 0);
    pend = -1;
    tick();
    rst = 1'b0;
    tick();
    chk_all("postrst", 0, 0, 0, 0, 0, 0, 2'b00, 0);
    run_nominal(n, 0, 1'b0);

    // Spurious all-ones during every START cycle
    run_nominal(10, 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Initiator for the per-neuron controller handshake: pulses start to one layer of neurons, waits for their ready, latches the layer result, then advances to the next layer.
- Sits between the input-sample interface (valid/ready) and the output interface (valid/ready).
- Drives layer_idx, which selects weight banks and the layer-output buffer.
- Includes a watchdog and a ready-consistency check.

Parameters:
- NUM_LAYERS, 3, number of layers sequenced per inference (>=1)
- M, 4, neurons per layer; width of neuron_ready
- TIMEOUT, 32, maximum WAIT cycles before a timeout error (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample available
- in_ready  out  1  sequencer can accept a sample
- ld_input  out  1  load input buffer (1-cycle pulse on in handshake)
- neuron_start  out  1  start pulse to all M neurons of the current layer
- neuron_ready  in  M  per-neuron ready pulses
- ld_layer_out  out  1  latch current layer outputs (1-cycle pulse)
- layer_idx  out  $clog2(NUM_LAYERS) (min 1)  current layer
- out_valid  out  1  final result valid
- out_ready  in  1  downstream accepts result
- busy  out  1  high in every state except IDLE
- err  out  1  sticky error flag
- err_code  out  2  01 timeout, 10 ready mismatch, 00 none
- clr_err  in  1  clears the error, returns to IDLE

Behaviour:
- Reset: state=IDLE, layer_idx=0, watchdog=0, err=0, err_code=00, in_ready=1, all pulses and out_valid=0. Reset mid-operation aborts the inference immediately; no ld pulse is produced.
- States:
  - IDLE
  - START
  - WAIT
  - OUTPUT
  - ERROR
- All outputs are decoded from state and registered counters only, except ld_input and ld_layer_out, which are qualified by their same-cycle inputs as listed below.
- IDLE:
  - in_ready=1.
  - If in_valid: ld_input=1 this cycle, layer_idx<=0, go to START.
- START:
  - neuron_start=1 for exactly one cycle; watchdog<=0; go to WAIT.
  - neuron_ready seen in START is ignored.
- WAIT, evaluated each cycle in this order:
  - a) neuron_ready all ones: ld_layer_out=1 this cycle, watchdog cleared. If layer_idx==NUM_LAYERS-1 go to OUTPUT, else layer_idx+=1 and go to START.
  - b) neuron_ready nonzero but not all ones: go to ERROR, err_code<=10, no ld_layer_out.
  - c) watchdog==TIMEOUT-1: go to ERROR, err_code<=01.
  - d) otherwise watchdog+=1.
- OUTPUT:
  - out_valid=1, held until out_ready; on out_valid&out_ready go to IDLE.
  - in_ready=0 throughout.
- ERROR:
  - err=1 with err_code held; in_ready=0.
  - clr_err clears err and err_code, layer_idx<=0, go to IDLE.
  - clr_err is ignored in all other states.
- in_valid is ignored outside IDLE. out_ready is ignored outside OUTPUT.
- Timing with conforming neurons of N inputs:
  - Ready arrives N+2 cycles after the START cycle, so the per-layer period is N+3 cycles.
  - With acceptance at cycle 0, out_valid rises at cycle 1+NUM_LAYERS*(N+3).
- The watchdog counter is $clog2(TIMEOUT) bits and never wraps, because case (c) exits first.
- NUM_LAYERS=1: layer_idx stays 0; after the first capture the block goes straight to OUTPUT.

Decomposition:
- Shared package: state encodings (IDLE, START, WAIT, OUTPUT, ERROR) and error codes (ERR_NONE, ERR_TIMEOUT, ERR_MISMATCH), shared with the neuron/network top for debug decode.
- One natural sub-module, layer_watchdog: a clearable up-counter with a terminal-count flag at TIMEOUT-1.
- Layer counter and FSM remain in layer_sequencer.

Test Plan:
- Nominal, NUM_LAYERS=3, M=4, behavioural neurons with N=10, in_valid at cycle 0:
  - ld_input at cycle 0.
  - neuron_start at cycles 1, 14, 27.
  - ld_layer_out at 13, 26, 39 with layer_idx 0, 1, 2.
  - out_valid at 40; with out_ready=1, IDLE and in_ready=1 at 41.
- Backpressure: out_ready held 0 for 5 cycles after out_valid. out_valid stays 1, in_ready stays 0, and an in_valid pulse during this window is not accepted; IDLE one cycle after out_ready=1.
- Timeout, TIMEOUT=32, neurons never ready:
  - WAIT covers cycles 2..33.
  - ERROR at 34 with err=1, err_code=01, and no ld_layer_out.
  - clr_err at 40 gives IDLE at 41 with err=0.
- Mismatch: in WAIT of layer 1, neuron_ready=4'b0111. Next cycle ERROR with err_code=10, no ld_layer_out, layer_idx held at 1.
- Reset mid-operation: assert rst during WAIT of layer 1. Immediately all pulses and out_valid are 0, layer_idx=0, busy=0, and in_ready=1. After release, a fresh sample runs nominally with identical timing.
- Spurious ready: neuron_ready=4'b1111 during a START cycle is ignored (no ld_layer_out, no layer advance); the real ready later is captured normally.
